// File: rtl/adsr_envelope_pkg.sv
// Shared types and default widths for the ADSR envelope voice stage.
package adsr_envelope_pkg;

    localparam int ENV_BITS_DEFAULT    = 16;
    localparam int RATE_BITS_DEFAULT   = 16;
    localparam int SYNTH_WIDTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/adsr_envelope_vca.sv
// Two-stage gain pipeline: signed sample times unsigned envelope level, scaled back by ENV_BITS.
module adsr_envelope_vca #(
    parameter int SYNTH_WIDTH = 16,
    parameter int ENV_BITS    = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic signed [SYNTH_WIDTH-1:0] sample_in,
    input  logic        [ENV_BITS-1:0]    level_in,
    output logic signed [SYNTH_WIDTH-1:0] val_out
);

    localparam int PROD_BITS = SYNTH_WIDTH + ENV_BITS + 1;

    logic signed [SYNTH_WIDTH-1:0] sample_q;
    logic        [ENV_BITS-1:0]    level_q;
    logic signed [PROD_BITS-1:0]   product_q;
    logic signed [SYNTH_WIDTH-1:0] val_q;

    // The level is at most just under unity gain, so the scaled product always fits SYNTH_WIDTH.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_q  <= '0;
            level_q   <= '0;
            product_q <= '0;
            val_q     <= '0;
        end else begin
            sample_q  <= sample_in;
            level_q   <= level_in;
            product_q <= sample_q * $signed({1'b0, level_q});
            val_q     <= SYNTH_WIDTH'(product_q >>> ENV_BITS);
        end
    end

    assign val_out = val_q;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator with VCA; define ADSR_EXP_RELEASE_EN for exponential release.
module adsr_envelope
    import adsr_envelope_pkg::*;
#(
    parameter int SYNTH_WIDTH = SYNTH_WIDTH_DEFAULT,
    parameter int ENV_BITS    = ENV_BITS_DEFAULT,
    parameter int RATE_BITS   = RATE_BITS_DEFAULT
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          gate_in,
    input  logic                          tick_in,
    input  logic        [RATE_BITS-1:0]   attack_rate_in,
    input  logic        [RATE_BITS-1:0]   decay_rate_in,
    input  logic        [ENV_BITS-1:0]    sustain_level_in,
    input  logic        [RATE_BITS-1:0]   release_rate_in,
    input  logic signed [SYNTH_WIDTH-1:0] sample_in,
    output logic signed [SYNTH_WIDTH-1:0] val_out,
    output logic        [ENV_BITS-1:0]    env_out,
    output logic                          active_out,
    output logic        [2:0]             state_out
);

    // Signed headroom wide enough for either operand plus carry/borrow.
    localparam int CALC_BITS = ((ENV_BITS > RATE_BITS) ? ENV_BITS : RATE_BITS) + 2;
    localparam logic signed [CALC_BITS-1:0] ENV_MAX_X = CALC_BITS'((64'd1 << ENV_BITS) - 64'd1);
    localparam logic        [ENV_BITS-1:0]  ENV_MAX   = '1;

    env_state_t            state_q, state_d;
    logic [ENV_BITS-1:0]   level_q, level_d;
    logic                  gate_q;
    logic                  active_q;

    logic                  rise_w, fall_w;
    logic signed [CALC_BITS-1:0] lvl_x, sus_x, rel_step_x;
    logic signed [CALC_BITS-1:0] atk_sum_x, dec_diff_x, rel_diff_x;

    assign rise_w = gate_in & ~gate_q;
    assign fall_w = ~gate_in & gate_q;

    always_comb begin
        lvl_x = CALC_BITS'(level_q);
        sus_x = CALC_BITS'(sustain_level_in);
`ifdef ADSR_EXP_RELEASE_EN
        rel_step_x = CALC_BITS'(level_q >> release_rate_in[3:0]);
        if (rel_step_x == '0) begin
            rel_step_x = CALC_BITS'(1);
        end
`else
        rel_step_x = CALC_BITS'(release_rate_in);
`endif
        atk_sum_x  = lvl_x + CALC_BITS'(attack_rate_in);
        dec_diff_x = lvl_x - CALC_BITS'(decay_rate_in);
        rel_diff_x = lvl_x - rel_step_x;
    end

    // Gate edges take priority over the tick; the level is frozen on an edge cycle.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (rise_w) begin
            state_d = ENV_ATTACK;
        end else if (fall_w && (state_q == ENV_ATTACK || state_q == ENV_DECAY ||
                                state_q == ENV_SUSTAIN)) begin
            state_d = ENV_RELEASE;
        end else begin
            case (state_q)
                ENV_SUSTAIN: level_d = sustain_level_in;
                ENV_ATTACK: begin
                    if (tick_in) begin
                        if (atk_sum_x >= ENV_MAX_X) begin
                            level_d = ENV_MAX;
                            state_d = ENV_DECAY;
                        end else begin
                            level_d = ENV_BITS'(atk_sum_x);
                        end
                    end
                end
                ENV_DECAY: begin
                    if (tick_in) begin
                        if (dec_diff_x <= sus_x) begin
                            level_d = sustain_level_in;
                            state_d = ENV_SUSTAIN;
                        end else begin
                            level_d = ENV_BITS'(dec_diff_x);
                        end
                    end
                end
                ENV_RELEASE: begin
                    if (tick_in) begin
                        if (rel_diff_x <= 0) begin
                            level_d = '0;
                            state_d = ENV_IDLE;
                        end else begin
                            level_d = ENV_BITS'(rel_diff_x);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ENV_IDLE;
            level_q  <= '0;
            gate_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            gate_q   <= gate_in;
            active_q <= (state_d != ENV_IDLE);
        end
    end

    assign env_out    = level_q;
    assign state_out  = state_q;
    assign active_out = active_q;

    adsr_envelope_vca #(
        .SYNTH_WIDTH (SYNTH_WIDTH),
        .ENV_BITS    (ENV_BITS)
    ) u_vca (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .sample_in (sample_in),
        .level_in  (level_q),
        .val_out   (val_out)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed plus randomized bench for adsr_envelope against an arithmetic reference model.
module tb_adsr_envelope;

    localparam int MAXV   = 65535;
    localparam int S_IDLE = 0;
    localparam int S_ATT  = 1;
    localparam int S_DEC  = 2;
    localparam int S_SUS  = 3;
    localparam int S_REL  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               gate;
    logic               tick;
    logic [15:0]        ar, dr, sus, rr;
    logic signed [15:0] samp;
    logic signed [15:0] val;
    logic [15:0]        env;
    logic               active;
    logic [2:0]         st;

    int checks = 0;
    int errors = 0;

    int m_state = 0;
    int m_level = 0;
    int m_gate  = 0;
    int q_samp[$];
    int q_lvl[$];

    adsr_envelope dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .gate_in          (gate),
        .tick_in          (tick),
        .attack_rate_in   (ar),
        .decay_rate_in    (dr),
        .sustain_level_in (sus),
        .release_rate_in  (rr),
        .sample_in        (samp),
        .val_out          (val),
        .env_out          (env),
        .active_out       (active),
        .state_out        (st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int rel_dec(input int lvl, input int rate);
        int d;
`ifdef ADSR_EXP_RELEASE_EN
        d = lvl >> (rate & 15);
        if (d < 1) d = 1;
`else
        d = rate;
`endif
        return d;
    endfunction

    // One clock: advance the reference model from the pre-edge inputs, then compare.
    task automatic step();
        int ns, nl, ng, rise, fall, exp_val;
        longint p;
        if (rst) begin
            ns = S_IDLE; nl = 0; ng = 0;
            q_samp.delete();
            q_lvl.delete();
        end else begin
            q_samp.push_back(int'(samp));
            q_lvl.push_back(m_level);
            ns = m_state; nl = m_level; ng = int'(gate);
            rise = (gate && m_gate == 0) ? 1 : 0;
            fall = (!gate && m_gate == 1) ? 1 : 0;
            if (rise == 1) begin
                ns = S_ATT;
            end else if (fall == 1 && (m_state inside {S_ATT, S_DEC, S_SUS})) begin
                ns = S_REL;
            end else if (m_state == S_SUS) begin
                nl = int'(sus);
            end else if (tick) begin
                case (m_state)
                    S_ATT: begin
                        nl = m_level + int'(ar);
                        if (nl >= MAXV) begin nl = MAXV; ns = S_DEC; end
                    end
                    S_DEC: begin
                        nl = m_level - int'(dr);
                        if (nl <= int'(sus)) begin nl = int'(sus); ns = S_SUS; end
                    end
                    S_REL: begin
                        nl = m_level - rel_dec(m_level, int'(rr));
                        if (nl <= 0) begin nl = 0; ns = S_IDLE; end
                    end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        m_state = ns; m_level = nl; m_gate = ng;
        exp_val = 0;
        if (q_samp.size() >= 3) begin
            p = longint'(q_samp[0]) * longint'(q_lvl[0]);
            exp_val = int'(p >>> 16);
            void'(q_samp.pop_front());
            void'(q_lvl.pop_front());
        end
        chk("model_state", st, m_state);
        chk("model_level", env, m_level);
        chk("model_active", active, (m_state != S_IDLE) ? 1 : 0);
        chk("model_val", val, exp_val);
    endtask

    initial begin
        int exp_att[4];
        int exp_dec[4];
        int rel_lvl;
        int att_lvl;

        exp_att = '{16384, 32768, 49152, 65535};
        exp_dec = '{57343, 49151, 40959, 40000};

        rst = 1'b1; gate = 1'b0; tick = 1'b1;
        ar = 16'd16384; dr = 16'd8192; sus = 16'd40000;
`ifdef ADSR_EXP_RELEASE_EN
        rr = 16'd2;
`else
        rr = 16'd20000;
`endif
        samp = '0;
        step();
        step();
        chk("reset_state", st, S_IDLE);
        chk("reset_env", env, 0);
        chk("reset_active", active, 0);
        chk("reset_val", val, 0);

        // Attack then decay to sustain
        rst = 1'b0; gate = 1'b1; samp = 16'($urandom);
        step();
        chk("attack_entry_state", st, S_ATT);
        chk("attack_entry_env", env, 0);
        for (int i = 0; i < 4; i++) begin
            samp = 16'($urandom);
            step();
            chk("attack_level", env, exp_att[i]);
        end
        chk("attack_to_decay", st, S_DEC);
        for (int i = 0; i < 4; i++) begin
            samp = 16'($urandom);
            step();
            chk("decay_level", env, exp_dec[i]);
        end
        chk("decay_to_sustain", st, S_SUS);

        // Gain through the pipeline
        sus = 16'd32768; samp = 16'sd16384;
        repeat (4) step();
        chk("gain_half", val, 8192);
        sus = 16'd65535; samp = 16'sh8000;
        repeat (4) step();
        chk("gain_full_negative", val, -32768);
        sus = 16'd40000; samp = 16'($urandom);
        step();

        // Release
        gate = 1'b0;
        step();
        chk("release_entry_state", st, S_REL);
        chk("release_entry_env", env, 40000);
`ifdef ADSR_EXP_RELEASE_EN
        step(); chk("exp_release_1", env, 30000);
        step(); chk("exp_release_2", env, 22500);
        step(); chk("exp_release_3", env, 16875);
        for (int i = 0; i < 100 && m_state != S_IDLE; i++) step();
`else
        step(); chk("release_1", env, 20000);
        step(); chk("release_2", env, 0);
`endif
        chk("release_idle_state", st, S_IDLE);
        chk("release_idle_active", active, 0);

        // Retrigger from RELEASE keeps the level
        gate = 1'b1;
        step();
        for (int i = 0; i < 100 && m_state != S_SUS; i++) step();
        chk("retrig_reach_sustain", st, S_SUS);
        gate = 1'b0;
        step();
        step();
`ifdef ADSR_EXP_RELEASE_EN
        rel_lvl = 30000;
`else
        rel_lvl = 20000;
`endif
        chk("retrig_release_level", env, rel_lvl);
        gate = 1'b1;
        step();
        chk("retrig_state", st, S_ATT);
        chk("retrig_hold_level", env, rel_lvl);
        step();
        att_lvl = rel_lvl + 16384;
        chk("retrig_first_tick", env, att_lvl);

        // Edge with tick on the same cycle: edge wins, level frozen
        gate = 1'b0;
        step();
        chk("edge_tick_fall_state", st, S_REL);
        chk("edge_tick_fall_level", env, att_lvl);
        gate = 1'b1;
        step();
        chk("edge_tick_rise_state", st, S_ATT);
        chk("edge_tick_rise_level", env, att_lvl);
        step();
        chk("attack_after_edges", env, (att_lvl + 16384 > MAXV) ? MAXV : att_lvl + 16384);

        // Reset mid-attack
        rst = 1'b1;
        step();
        chk("midnote_reset_state", st, S_IDLE);
        chk("midnote_reset_env", env, 0);
        chk("midnote_reset_val", val, 0);
        step();
        rst = 1'b0;

        // Randomized phase
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 15) == 0) gate = ~gate;
            tick = 1'($urandom_range(0, 1));
            samp = 16'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                ar  = 16'($urandom_range(0, 20000));
                dr  = 16'($urandom_range(0, 20000));
                sus = 16'($urandom);
`ifdef ADSR_EXP_RELEASE_EN
                rr  = 16'($urandom);
`else
                rr  = 16'($urandom_range(0, 20000));
`endif
            end
            rst = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
